// File: rtl/zig_zag_ctrl_if.sv
// ----------------------------------------------------------------------------
// zig_zag_ctrl_if
// Bundles the quantizer-side write handshake, the zig-zag RAM strobes and the
// Huffman-side read handshake of the zig-zag buffer controller.
//   slave  : controller view (takes coefficients and read requests, drives RAM)
//   master : environment view (quantizer, Huffman stage, RAM)
// Signals:
//   coef_valid / coef_data / eof_in / coef_ready  : quantizer handshake
//   zig_zag_wr_en / zig_zag_wr_addr / zig_zag_wr_data : RAM write port
//   huffman_start / huff_req / huff_valid / huff_last / eof_out : Huffman side
//   zig_zag_rd_en / zig_zag_rd_addr               : RAM read port
// ----------------------------------------------------------------------------
interface zig_zag_ctrl_if #(
  parameter int DATA_W = 12
);
  logic              coef_valid;
  logic [DATA_W-1:0] coef_data;
  logic              eof_in;
  logic              coef_ready;
  logic              zig_zag_wr_en;
  logic [5:0]        zig_zag_wr_addr;
  logic [DATA_W-1:0] zig_zag_wr_data;
  logic              huffman_start;
  logic              huff_req;
  logic              zig_zag_rd_en;
  logic [5:0]        zig_zag_rd_addr;
  logic              huff_valid;
  logic              huff_last;
  logic              eof_out;

  modport slave (
    input  coef_valid, coef_data, eof_in, huff_req,
    output coef_ready, zig_zag_wr_en, zig_zag_wr_addr, zig_zag_wr_data,
           huffman_start, zig_zag_rd_en, zig_zag_rd_addr,
           huff_valid, huff_last, eof_out
  );

  modport master (
    output coef_valid, coef_data, eof_in, huff_req,
    input  coef_ready, zig_zag_wr_en, zig_zag_wr_addr, zig_zag_wr_data,
           huffman_start, zig_zag_rd_en, zig_zag_rd_addr,
           huff_valid, huff_last, eof_out
  );
endinterface

// File: rtl/zig_zag_ctrl.sv
// ----------------------------------------------------------------------------
// zig_zag_ctrl
// Sequencer for the 64-entry single-port zig-zag coefficient buffer.
// FILL  : raster-order coefficients are written at their zig-zag address.
// FLUSH : one cycle while the final write is on the RAM bus.
// DRAIN : Huffman read requests are granted in address order 0..63.
// Writes and reads live in disjoint states, so the RAM port never collides.
// Ports:
//   clk_in : clock, rising edge
//   rst    : asynchronous reset, active low
//   bus    : zig_zag_ctrl_if slave modport (quantizer, RAM, Huffman signals)
// ----------------------------------------------------------------------------
module zig_zag_ctrl #(
  parameter int DATA_W = 12
) (
  input logic           clk_in,
  input logic           rst,
  zig_zag_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        wr_cnt_q, wr_cnt_d;
  logic [5:0]        rd_cnt_q, rd_cnt_d;
  logic              eof_flag_q, eof_flag_d;
  logic              coef_ready_q, coef_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [5:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              xfer_s;
  logic              grant_s;
  logic              eof_out_s;

  // Raster index (row*8+col) to JPEG zig-zag position.
  function automatic logic [5:0] zz_map(input logic [5:0] raster);
    logic [5:0] zz;
    zz = 6'd0;
    case (raster)
      6'd0:  zz = 6'd0;  6'd1:  zz = 6'd1;  6'd2:  zz = 6'd5;  6'd3:  zz = 6'd6;
      6'd4:  zz = 6'd14; 6'd5:  zz = 6'd15; 6'd6:  zz = 6'd27; 6'd7:  zz = 6'd28;
      6'd8:  zz = 6'd2;  6'd9:  zz = 6'd4;  6'd10: zz = 6'd7;  6'd11: zz = 6'd13;
      6'd12: zz = 6'd16; 6'd13: zz = 6'd26; 6'd14: zz = 6'd29; 6'd15: zz = 6'd42;
      6'd16: zz = 6'd3;  6'd17: zz = 6'd8;  6'd18: zz = 6'd12; 6'd19: zz = 6'd17;
      6'd20: zz = 6'd25; 6'd21: zz = 6'd30; 6'd22: zz = 6'd41; 6'd23: zz = 6'd43;
      6'd24: zz = 6'd9;  6'd25: zz = 6'd11; 6'd26: zz = 6'd18; 6'd27: zz = 6'd24;
      6'd28: zz = 6'd31; 6'd29: zz = 6'd40; 6'd30: zz = 6'd44; 6'd31: zz = 6'd53;
      6'd32: zz = 6'd10; 6'd33: zz = 6'd19; 6'd34: zz = 6'd23; 6'd35: zz = 6'd32;
      6'd36: zz = 6'd39; 6'd37: zz = 6'd45; 6'd38: zz = 6'd52; 6'd39: zz = 6'd54;
      6'd40: zz = 6'd20; 6'd41: zz = 6'd22; 6'd42: zz = 6'd33; 6'd43: zz = 6'd38;
      6'd44: zz = 6'd46; 6'd45: zz = 6'd51; 6'd46: zz = 6'd55; 6'd47: zz = 6'd60;
      6'd48: zz = 6'd21; 6'd49: zz = 6'd34; 6'd50: zz = 6'd37; 6'd51: zz = 6'd47;
      6'd52: zz = 6'd50; 6'd53: zz = 6'd56; 6'd54: zz = 6'd59; 6'd55: zz = 6'd61;
      6'd56: zz = 6'd35; 6'd57: zz = 6'd36; 6'd58: zz = 6'd48; 6'd59: zz = 6'd49;
      6'd60: zz = 6'd57; 6'd61: zz = 6'd58; 6'd62: zz = 6'd62; 6'd63: zz = 6'd63;
      default: zz = 6'd0;
    endcase
    return zz;
  endfunction

  // coef_ready_q is high exactly while the state register holds FILL.
  assign xfer_s    = bus.coef_valid & coef_ready_q;
  // Read grants are combinational on the request, but only in DRAIN.
  assign grant_s   = bus.huff_req & (state_q == DRAIN);
  assign eof_out_s = last_q & eof_flag_q;

  // Next-state and next-output logic for the fill/flush/drain sequencer.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    start_d    = 1'b0;
    valid_d    = grant_s;
    last_d     = grant_s & (rd_cnt_q == 6'd63);
    // The flag is consumed by the eof_out beat it qualifies.
    eof_flag_d = eof_out_s ? 1'b0 : eof_flag_q;

    case (state_q)
      FILL: begin
        if (xfer_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = zz_map(wr_cnt_q);
          wr_data_d = bus.coef_data;
          wr_cnt_d  = wr_cnt_q + 6'd1;
          if (wr_cnt_q == 6'd63) begin
            eof_flag_d = bus.eof_in;
            state_d    = FLUSH;
          end else begin
            state_d    = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      FLUSH: begin
        // Final write is on the bus now; start pulse lands on the first DRAIN cycle.
        start_d = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (grant_s) begin
          rd_cnt_d = rd_cnt_q + 6'd1;
          if (rd_cnt_q == 6'd63) begin
            state_d = FILL;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    coef_ready_d = (state_d == FILL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      wr_cnt_q     <= 6'd0;
      rd_cnt_q     <= 6'd0;
      eof_flag_q   <= 1'b0;
      coef_ready_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 6'd0;
      wr_data_q    <= {DATA_W{1'b0}};
      start_q      <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      eof_flag_q   <= eof_flag_d;
      coef_ready_q <= coef_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      start_q      <= start_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
    end
  end

  assign bus.coef_ready      = coef_ready_q;
  assign bus.zig_zag_wr_en   = wr_en_q;
  assign bus.zig_zag_wr_addr = wr_addr_q;
  assign bus.zig_zag_wr_data = wr_data_q;
  assign bus.huffman_start   = start_q;
  assign bus.zig_zag_rd_en   = grant_s;
  assign bus.zig_zag_rd_addr = rd_cnt_q;
  assign bus.huff_valid      = valid_q;
  assign bus.huff_last       = last_q;
  assign bus.eof_out         = eof_out_s;

endmodule

// File: tb/tb_zig_zag_ctrl.sv
// ----------------------------------------------------------------------------
// tb_zig_zag_ctrl
// Directed bench for zig_zag_ctrl with a behavioural RAM. Inputs change 1 ns
// after the rising edge; a negedge monitor logs transfers, writes, grants,
// read beats and start pulses with their cycle number, and the test body
// compares those logs with hand-derived expectations.
// ----------------------------------------------------------------------------
module tb_zig_zag_ctrl;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  zig_zag_ctrl_if #(.DATA_W(12)) bus ();

  zig_zag_ctrl #(.DATA_W(12)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { int cyc; int addr; int data; } wr_ev_t;
  typedef struct { int cyc; int addr; } rd_ev_t;
  typedef struct { int cyc; int data; int last; int eof; } beat_t;
  typedef struct { int raster; int zz; } zz_vec_t;

  int     xq[$];
  wr_ev_t wq[$];
  rd_ev_t rq[$];
  beat_t  vq[$];
  int     sq[$];
  bit     ready_log [0:8191];

  // JPEG zig-zag scan order: position k holds raster index zz_order[k].
  int zz_order [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  int zz_inv [64];

  // Behavioural single-port RAM
  logic [11:0] mem [64];
  logic [11:0] rdata = 12'd0;
  always @(posedge clk_in) begin
    if (bus.zig_zag_wr_en) mem[bus.zig_zag_wr_addr] <= bus.zig_zag_wr_data;
    if (bus.zig_zag_rd_en) rdata <= mem[bus.zig_zag_rd_addr];
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ready_at(input int c);
    if (c >= 0 && c < 8192) return int'(ready_log[c]);
    return 2;
  endfunction

  // Event logger plus per-cycle invariants
  always @(negedge clk_in) begin
    if (cyc < 8192) ready_log[cyc] = bus.coef_ready;
    if (bus.coef_valid && bus.coef_ready) xq.push_back(cyc);
    if (bus.zig_zag_wr_en)
      wq.push_back(wr_ev_t'{cyc, int'(bus.zig_zag_wr_addr), int'(bus.zig_zag_wr_data)});
    if (bus.zig_zag_rd_en) rq.push_back(rd_ev_t'{cyc, int'(bus.zig_zag_rd_addr)});
    if (bus.huff_valid)
      vq.push_back(beat_t'{cyc, int'(rdata), int'(bus.huff_last), int'(bus.eof_out)});
    if (bus.huffman_start) sq.push_back(cyc);
    if (bus.zig_zag_wr_en || bus.zig_zag_rd_en)
      chk("wr_rd_exclusive", int'(bus.zig_zag_wr_en & bus.zig_zag_rd_en), 0);
    if (bus.zig_zag_rd_en) chk("rd_en_needs_req", int'(bus.huff_req), 1);
    if (bus.huff_last) chk("last_needs_valid", int'(bus.huff_valid), 1);
    if (bus.eof_out) chk("eof_needs_last", int'(bus.huff_last), 1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic clear_logs();
    xq.delete(); wq.delete(); rq.delete(); vq.delete(); sq.delete();
  endtask

  task automatic send_coef(input int d, input logic e);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    bus.coef_valid = 1'b1;
    bus.coef_data  = 12'(d);
    bus.eof_in     = e;
    while (!ok && n < 1000) begin
      @(negedge clk_in);
      ok = bus.coef_ready;
      @(posedge clk_in);
      #1;
      n++;
    end
    bus.coef_valid = 1'b0;
    bus.eof_in     = 1'b0;
    if (!ok) chk("coef_accept_timeout", 0, 1);
  endtask

  task automatic send_block(input int base, input logic eof63, input logic eof10, input int gap_max);
    for (int i = 0; i < 64; i++) begin
      if (gap_max > 0) tick($urandom_range(0, gap_max));
      send_coef(base + i, (i == 63) ? eof63 : ((i == 10) ? eof10 : 1'b0));
    end
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (vq.size() < n && k < 1000) begin
      tick(1);
      k++;
    end
    if (vq.size() < n) chk("beat_wait_timeout", vq.size(), n);
  endtask

  task automatic check_writes(input int off, input int base);
    chk("write_count", (wq.size() >= off + 64) ? 1 : 0, 1);
    for (int i = 0; i < 64 && off + i < wq.size(); i++) begin
      chk("write_addr", wq[off+i].addr, zz_inv[i]);
      chk("write_data", wq[off+i].data, base + i);
      if (off + i < xq.size()) chk("write_latency", wq[off+i].cyc, xq[off+i] + 1);
    end
  endtask

  task automatic check_reads(input int off, input int base, input int exp_eof);
    chk("grant_count", (rq.size() >= off + 64) ? 1 : 0, 1);
    chk("beat_count", (vq.size() >= off + 64) ? 1 : 0, 1);
    for (int k = 0; k < 64 && off + k < rq.size() && off + k < vq.size(); k++) begin
      chk("read_addr", rq[off+k].addr, k);
      chk("read_latency", vq[off+k].cyc, rq[off+k].cyc + 1);
      chk("read_data", vq[off+k].data, base + zz_order[k]);
      chk("huff_last", vq[off+k].last, (k == 63) ? 1 : 0);
      chk("eof_out", vq[off+k].eof, (k == 63) ? exp_eof : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_coef_ready"}, int'(bus.coef_ready), 1);
    chk({tag, "_wr_en"}, int'(bus.zig_zag_wr_en), 0);
    chk({tag, "_wr_addr"}, int'(bus.zig_zag_wr_addr), 0);
    chk({tag, "_wr_data"}, int'(bus.zig_zag_wr_data), 0);
    chk({tag, "_start"}, int'(bus.huffman_start), 0);
    chk({tag, "_rd_en"}, int'(bus.zig_zag_rd_en), 0);
    chk({tag, "_rd_addr"}, int'(bus.zig_zag_rd_addr), 0);
    chk({tag, "_valid"}, int'(bus.huff_valid), 0);
    chk({tag, "_last"}, int'(bus.huff_last), 0);
    chk({tag, "_eof_out"}, int'(bus.eof_out), 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_reset_outputs({tag, "_rel"});
  endtask

  zz_vec_t zz_tbl [10];

  initial begin
    int last_g;
    int n;

    zz_tbl[0] = '{0, 0};   zz_tbl[1] = '{1, 1};   zz_tbl[2] = '{8, 2};
    zz_tbl[3] = '{16, 3};  zz_tbl[4] = '{9, 4};   zz_tbl[5] = '{2, 5};
    zz_tbl[6] = '{7, 28};  zz_tbl[7] = '{56, 35}; zz_tbl[8] = '{62, 62};
    zz_tbl[9] = '{63, 63};
    for (int k = 0; k < 64; k++) zz_inv[zz_order[k]] = k;

    bus.coef_valid = 1'b0;
    bus.coef_data  = 12'd0;
    bus.eof_in     = 1'b0;
    bus.huff_req   = 1'b0;

    // Power-on reset
    #2;
    pulse_reset("por");
    clear_logs();

    // Block 1: raster-index data, no reads yet
    send_block(0, 1'b0, 1'b0, 0);
    tick(3);
    check_writes(0, 0);
    for (int t = 0; t < 10; t++) begin
      if (zz_tbl[t].raster < wq.size()) begin
        chk("zz_table_addr", wq[zz_tbl[t].raster].addr, zz_tbl[t].zz);
        chk("zz_table_data", wq[zz_tbl[t].raster].data, zz_tbl[t].raster);
      end else begin
        chk("zz_table_missing", wq.size(), 64);
      end
    end
    if (xq.size() == 64) begin
      chk("ready_at_last_xfer", ready_at(xq[63]), 1);
      chk("ready_drop_flush", ready_at(xq[63] + 1), 0);
      chk("start_count", sq.size(), 1);
      if (sq.size() > 0) chk("start_cycle", sq[0], xq[63] + 2);
    end else begin
      chk("xfer_count", xq.size(), 64);
    end
    chk("no_grant_without_req", rq.size(), 0);

    // Drain block 1 with huff_req held for 64 cycles
    bus.huff_req = 1'b1;
    tick(64);
    bus.huff_req = 1'b0;
    tick(3);
    check_reads(0, 0, 0);
    if (rq.size() == 64) begin
      last_g = rq[63].cyc;
      chk("drain_back_to_back", last_g - rq[0].cyc, 63);
      chk("ready_low_last_grant", ready_at(last_g), 0);
      chk("ready_back_after_drain", ready_at(last_g + 1), 1);
    end

    // eof on coefficient 63, then eof only on coefficient 10
    clear_logs();
    send_block(200, 1'b1, 1'b0, 0);
    bus.huff_req = 1'b1;
    wait_beats(64);
    bus.huff_req = 1'b0;
    check_reads(0, 200, 1);
    clear_logs();
    send_block(300, 1'b0, 1'b1, 0);
    bus.huff_req = 1'b1;
    wait_beats(64);
    bus.huff_req = 1'b0;
    check_reads(0, 300, 0);

    // Random gaps, huff_req toggling in every state
    clear_logs();
    fork
      send_block(100, 1'b0, 1'b0, 2);
      begin
        n = 0;
        while (rq.size() < 64 && n < 1500) begin
          bus.huff_req = 1'($urandom_range(0, 1));
          tick(1);
          n++;
        end
        bus.huff_req = 1'b0;
      end
    join
    tick(2);
    bus.huff_req = 1'b1;
    tick(20);
    bus.huff_req = 1'b0;
    chk("gap_no_grant_in_fill", rq.size(), 64);
    check_writes(0, 100);
    check_reads(0, 100, 0);
    if (sq.size() > 0) begin
      foreach (rq[g]) begin
        chk("gap_grant_after_start", (rq[g].cyc >= sq[0]) ? 1 : 0, 1);
        chk("gap_grant_ready_low", ready_at(rq[g].cyc), 0);
      end
    end else begin
      chk("gap_start_count", sq.size(), 1);
    end

    // Reset after 30 transfers
    clear_logs();
    for (int i = 0; i < 30; i++) send_coef(900 + i, 1'b1);
    pulse_reset("rst_fill");
    clear_logs();
    send_block(1000, 1'b0, 1'b0, 0);
    bus.huff_req = 1'b1;
    wait_beats(64);
    bus.huff_req = 1'b0;
    tick(2);
    chk("rst_fill_start_count", sq.size(), 1);
    check_writes(0, 1000);
    check_reads(0, 1000, 0);

    // Reset mid-drain of a block that carried eof
    clear_logs();
    send_block(2000, 1'b1, 1'b0, 0);
    bus.huff_req = 1'b1;
    n = 0;
    while (rq.size() < 20 && n < 200) begin
      tick(1);
      n++;
    end
    chk("mid_drain_grants", rq.size(), 20);
    pulse_reset("rst_drain");
    clear_logs();
    tick(10);
    chk("rst_drain_no_start", sq.size(), 0);
    chk("rst_drain_no_grant", rq.size(), 0);
    chk("rst_drain_no_beat", vq.size(), 0);
    send_block(3000, 1'b0, 1'b0, 0);
    wait_beats(64);
    bus.huff_req = 1'b0;
    check_writes(0, 3000);
    check_reads(0, 3000, 0);

    // Two blocks streamed with huff_req high throughout
    tick(2);
    clear_logs();
    bus.huff_req = 1'b1;
    send_block(500, 1'b0, 1'b0, 0);
    send_block(600, 1'b0, 1'b0, 0);
    wait_beats(128);
    bus.huff_req = 1'b0;
    check_writes(0, 500);
    check_writes(64, 600);
    check_reads(0, 500, 0);
    check_reads(64, 600, 0);
    if (wq.size() >= 65 && vq.size() >= 64 && rq.size() >= 65 && xq.size() >= 64) begin
      chk("stream_first_grant", rq[0].cyc, xq[63] + 2);
      chk("stream_write_after_last_data", wq[64].cyc, vq[63].cyc + 1);
      chk("stream_block_span", wq[64].cyc - xq[0], 130);
      chk("stream_grant_period", rq[64].cyc - rq[0].cyc, 129);
    end else begin
      chk("stream_event_count", wq.size(), 128);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
